fp_product_accumulator: RTL and testbench
=========================================

// Module: fp_product_accumulator
// PURPOSE
//  Downstream consumer of the FP32 multiplier output. Sums a stream of single-precision
//  products into one FP32 result, e.g. for dot products.
//  Addition is multi-cycle and FSM-driven: align, add, normalise.
//  Input is a valid/ready handshake with in_last marking the final product of a vector.
//  Output is a valid/ready handshake that carries the sum and a sticky overflow flag.
// PARAMETERS
//  EXP_W      8    exponent field width
//  MAN_W      23   stored mantissa width; the datapath uses MAN_W+2 bits (hidden bit + carry)
//  BIAS       127  exponent bias
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset
//  in_valid   in   1          in_data, in_ovf and in_last are valid
//  in_ready   out  1          block can accept an operand
//  in_data    in   32         FP32 product {sign, exp, man}
//  in_ovf     in   1          upstream multiplier overflow for this product
//  in_last    in   1          final operand of the current vector
//  out_valid  out  1          out_sum and out_ovf are valid
//  out_ready  in   1          downstream accepts the result
//  out_sum    out  32         accumulated FP32 sum
//  out_ovf    out  1          sticky overflow over the vector
//  busy       out  1          FSM is not in IDLE
// BEHAVIOUR
//  - Reset, asynchronous and active-low:
//    - outputs: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
//    - internal: acc=+0, sticky=0, state=IDLE.
//    - in_ready rises the first cycle after reset is released.
//  - Reset asserted mid-operation aborts the operation and discards the partial sum.
//  - States are IDLE, ALIGN, ADD, NORM, DONE.
//  - IDLE: in_ready=1. On in_valid&in_ready the block:
//    - latches the operand and in_last;
//    - sets sticky |= in_ovf;
//    - takes the next state from the list below.
//  - Next state after an accept in IDLE:
//    - operand exp==0 (zero or denormal) is treated as zero: acc is unchanged;
//      next state is DONE if last, else IDLE. This is a one-cycle accept.
//    - acc is zero: acc takes the operand (denormals already flushed); next state is DONE if last, else IDLE.
//    - otherwise: next state is ALIGN.
//  - ALIGN (1 cycle):
//    - order the two values by magnitude, comparing {exp, man};
//    - right-shift the smaller mantissa by the exponent difference;
//    - a difference >= MAN_W+2 zeroes the smaller mantissa;
//    - shifted-out bits are truncated; there is no rounding.
//  - ADD (1 cycle):
//    - equal signs: add magnitudes; the result takes the common sign.
//    - different signs: subtract the smaller magnitude from the larger; the result takes the larger's sign.
//    - an exact zero result gives acc=+0, then goes to NORM-exit.
//  - NORM (1 or more cycles):
//    - carry bit set: shift right 1 and exp+1 in a single cycle.
//    - otherwise: shift left 1 and exp-1 per cycle until the hidden bit is 1.
//    - exp reaching 0 flushes acc to +0.
//    - exp reaching 255 sets sticky=1 and acc=+0 (see CONFIGURATION).
//    - NORM-exit goes to DONE if last, else IDLE.
//  - DONE:
//    - out_valid=1, out_sum=acc, out_ovf=sticky, in_ready=0;
//    - all three outputs hold stable while out_ready=0;
//    - on out_ready the block clears acc=+0 and sticky=0, deasserts out_valid and goes to IDLE.
//  - Latency from accept to the next in_ready:
//    - zero operand: 1 cycle;
//    - no left shift: 4 cycles;
//    - worst case: 3 cycles + 24 NORM steps.
//  - out_valid rises the cycle after the final NORM/accept.
//  - in_ready is never 1 while out_valid=1, so no input is accepted while a result is pending.
//  - Sign of zero: the block always produces +0.
// CONFIGURATION
//  - FP_ACC_SATURATE_EN:
//    - defined: exponent overflow sets acc to the largest finite value of the result sign,
//      {sign, 8'hFE, 23'h7FFFFF}, sticky=1, and accumulation continues from that value.
//    - undefined: overflow flushes acc to +0 and sets sticky=1. This matches the
//      multiplier's flush-to-zero policy.
// STRUCTURE
//  - Package fp32_pkg:
//    - EXP_W, MAN_W, BIAS, EXP_MAX=255;
//    - fp32_t struct {sign, exp, man};
//    - acc_state_t enum.
//  - Sub-module fp32_align_shift (combinational): magnitude compare, swap, and right
//    barrel shift with saturation at MAN_W+2. It is instantiated once in ALIGN.
// TESTING
//  - 0x3FC00000 (1.5) then 0x40000000 (2.0, last) -> out_sum=0x40600000 (3.5), out_ovf=0.
//  - 0x40400000 (3.0) then 0xC0200000 (-2.5, last) -> out_sum=0x3F000000 (0.5) after 2 left-shift NORM cycles.
//  - 0x40400000 then 0xC0400000 (last) -> out_sum=0x00000000.
//  - 0x4B800000 (2^24) then 0x3F800000 (1.0, last) -> out_sum=0x4B800000 (truncated).
//  - 0x7F7FFFFF twice (last):
//    - macro undefined -> out_sum=0, out_ovf=1;
//    - FP_ACC_SATURATE_EN defined -> out_sum=0x7F7FFFFF, out_ovf=1.
//  - Hold out_ready=0 for 5 cycles -> out_sum stable and in_ready=0.
//    Then assert reset during NORM of the next vector -> all outputs 0 and busy=0 immediately.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, operand struct and accumulator FSM states.
package fp32_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    // Datapath mantissa: carry bit, hidden bit, stored fraction.
    localparam int unsigned DP_W    = MAN_W + 2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } acc_state_t;

endpackage

// File: rtl/fp32_align_shift.sv
// Orders two normal FP32 values by magnitude and right-shifts the smaller
// mantissa onto the larger exponent (truncating, saturating at DP_W).
module fp32_align_shift
    import fp32_pkg::*;
(
    input  fp32_t            a,
    input  fp32_t            b,
    output logic             big_sign,
    output logic [EXP_W-1:0] big_exp,
    output logic [DP_W-1:0]  big_man,
    output logic             lit_sign,
    output logic [DP_W-1:0]  lit_man
);

    fp32_t            hi;
    fp32_t            lo;
    logic [EXP_W-1:0] diff;

    // Magnitude compare on {exp, man}, swap, then barrel shift the smaller.
    always_comb begin
        if ({a.exp, a.man} >= {b.exp, b.man}) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        diff     = hi.exp - lo.exp;
        big_sign = hi.sign;
        big_exp  = hi.exp;
        big_man  = {2'b01, hi.man};
        lit_sign = lo.sign;
        if (32'(diff) >= DP_W) begin
            lit_man = '0;
        end else begin
            lit_man = {2'b01, lo.man} >> diff;
        end
    end

endmodule

// File: rtl/fp_product_accumulator.sv
// Accumulates a stream of FP32 products into one FP32 sum with a sticky
// overflow flag. Multi-cycle align/add/normalise, no rounding, denormals
// flushed to zero.
// Optional build macro FP_ACC_SATURATE_EN: exponent overflow saturates to the
// largest finite value of the result sign instead of flushing to +0.
module fp_product_accumulator
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_ovf,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_ovf,
    output logic        busy
);

    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_MAX - 1);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    acc_state_t       state;
    acc_state_t       state_nxt;
    acc_state_t       exit_st;
    fp32_t            acc;
    fp32_t            op;
    logic             sticky;
    logic             last_q;
    logic             armed;
    logic             accept;
    logic             norm_exit;

    logic             al_big_sign;
    logic [EXP_W-1:0] al_big_exp;
    logic [DP_W-1:0]  al_big_man;
    logic             al_lit_sign;
    logic [DP_W-1:0]  al_lit_man;

    logic             big_sign_q;
    logic [EXP_W-1:0] big_exp_q;
    logic [DP_W-1:0]  big_man_q;
    logic             lit_sign_q;
    logic [DP_W-1:0]  lit_man_q;
    logic [DP_W-1:0]  add_man;

    logic             w_sign;
    logic [EXP_W-1:0] w_exp;
    logic [DP_W-1:0]  w_man;

    fp32_align_shift u_align (
        .a        (acc),
        .b        (op),
        .big_sign (al_big_sign),
        .big_exp  (al_big_exp),
        .big_man  (al_big_man),
        .lit_sign (al_lit_sign),
        .lit_man  (al_lit_man)
    );

    // Magnitude add/subtract; the aligned larger operand never goes negative.
    always_comb begin
        if (big_sign_q == lit_sign_q) begin
            add_man = big_man_q + lit_man_q;
        end else begin
            add_man = big_man_q - lit_man_q;
        end
        exit_st   = last_q ? DONE : IDLE;
        norm_exit = w_man[DP_W-1] | w_man[DP_W-2] | (w_exp == EXP_ONE);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; result outputs read zero unless valid.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                accept   = in_valid & armed;
                if (accept) begin
                    if (in_data[MAN_W +: EXP_W] == '0 || acc.exp == '0) begin
                        state_nxt = in_last ? DONE : IDLE;
                    end else begin
                        state_nxt = ALIGN;
                    end
                end
            end
            ALIGN: state_nxt = ADD;
            ADD: begin
                state_nxt = (add_man == '0) ? exit_st : NORM;
            end
            NORM: begin
                if (norm_exit) begin
                    state_nxt = exit_st;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy    = (state != IDLE);
        out_sum = out_valid ? acc : '0;
        out_ovf = out_valid & sticky;
    end

    // Accumulator datapath: operand capture, alignment, add and normalisation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            op         <= '0;
            sticky     <= 1'b0;
            last_q     <= 1'b0;
            armed      <= 1'b0;
            big_sign_q <= 1'b0;
            big_exp_q  <= '0;
            big_man_q  <= '0;
            lit_sign_q <= 1'b0;
            lit_man_q  <= '0;
            w_sign     <= 1'b0;
            w_exp      <= '0;
            w_man      <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op     <= in_data;
                        last_q <= in_last;
                        sticky <= sticky | in_ovf;
                        if (in_data[MAN_W +: EXP_W] != '0 && acc.exp == '0) begin
                            acc <= in_data;
                        end
                    end
                end
                ALIGN: begin
                    big_sign_q <= al_big_sign;
                    big_exp_q  <= al_big_exp;
                    big_man_q  <= al_big_man;
                    lit_sign_q <= al_lit_sign;
                    lit_man_q  <= al_lit_man;
                end
                ADD: begin
                    w_sign <= big_sign_q;
                    w_exp  <= big_exp_q;
                    w_man  <= add_man;
                    if (add_man == '0) begin
                        acc <= '0;
                    end
                end
                NORM: begin
                    if (w_man[DP_W-1]) begin
                        // Carry: one right shift always lands the hidden bit.
                        if (w_exp == EXP_TOP) begin
                            sticky <= 1'b1;
`ifdef FP_ACC_SATURATE_EN
                            acc <= {w_sign, EXP_TOP, {MAN_W{1'b1}}};
`else
                            acc <= '0;
`endif
                        end else begin
                            acc <= {w_sign, w_exp + 1'b1, w_man[DP_W-2:1]};
                        end
                    end else if (w_man[DP_W-2]) begin
                        acc <= {w_sign, w_exp, w_man[MAN_W-1:0]};
                    end else if (w_exp == EXP_ONE) begin
                        acc <= '0;
                    end else begin
                        w_man <= w_man << 1;
                        w_exp <= w_exp - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc    <= '0;
                        sticky <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_product_accumulator.sv
// Directed scoreboard bench for fp_product_accumulator.
module tb_fp_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_ovf;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_ovf;
    logic        busy;

    fp_product_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] sum, input logic ovf);
        exp_t e;
        e.sum = sum;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    // Present one operand and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] d, input logic ovf, input logic last);
        int unsigned waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = ovf;
        in_last  = last;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_ovf   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a result, compare against the scoreboard, optionally stall.
    task automatic collect(input string tag, input int unsigned lat, input int unsigned hold);
        exp_t        e;
        int unsigned cnt = 0;
        while (cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (out_valid) break;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            e = '0;
            check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
        end
        if (lat != 0) check({tag, "_latency"}, cnt, lat);
        check({tag, "_sum"}, out_sum, e.sum);
        check({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, out_sum, e.sum);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ovf    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   out_sum,        32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // 1.5 + 2.0 = 3.5
        send(32'h3FC00000, 1'b0, 1'b0);
        push_exp(32'h40600000, 1'b0);
        send(32'h40000000, 1'b0, 1'b1);
        collect("add", 4, 0);

        // 3.0 - 2.5 = 0.5, two left shifts
        send(32'h40400000, 1'b0, 1'b0);
        push_exp(32'h3F000000, 1'b0);
        send(32'hC0200000, 1'b0, 1'b1);
        collect("sub_norm", 6, 0);

        // 3.0 - 3.0 = +0
        send(32'h40400000, 1'b0, 1'b0);
        push_exp(32'h00000000, 1'b0);
        send(32'hC0400000, 1'b0, 1'b1);
        collect("cancel", 0, 0);

        // 2^24 + 1.0 truncates away the 1.0
        send(32'h4B800000, 1'b0, 1'b0);
        push_exp(32'h4B800000, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        collect("trunc", 4, 0);

        // max finite + max finite overflows
        send(32'h7F7FFFFF, 1'b0, 1'b0);
`ifdef FP_ACC_SATURATE_EN
        push_exp(32'h7F7FFFFF, 1'b1);
`else
        push_exp(32'h00000000, 1'b1);
`endif
        send(32'h7F7FFFFF, 1'b0, 1'b1);
        collect("overflow", 4, 0);

        // 1 + 2 + 3 = 6
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h40000000, 1'b0, 1'b0);
        push_exp(32'h40C00000, 1'b0);
        send(32'h40400000, 1'b0, 1'b1);
        collect("three_term", 4, 0);

        // upstream overflow is sticky; 1 + 1 = 2
        send(32'h3F800000, 1'b1, 1'b0);
        push_exp(32'h40000000, 1'b1);
        send(32'h3F800000, 1'b0, 1'b1);
        collect("sticky_in", 4, 0);

        // zero and denormal are ignored, then 1.0 loads directly
        send(32'h00000000, 1'b0, 1'b0);
        send(32'h00000001, 1'b0, 1'b0);
        push_exp(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        collect("zero_skip", 1, 0);

        // single negative operand
        push_exp(32'hBFC00000, 1'b0);
        send(32'hBFC00000, 1'b0, 1'b1);
        collect("single_neg", 1, 0);

        // 1.0 - 3.0 = -2.0, larger operand's sign
        send(32'h3F800000, 1'b0, 1'b0);
        push_exp(32'hC0000000, 1'b0);
        send(32'hC0400000, 1'b0, 1'b1);
        collect("neg_result", 4, 0);

        // output back-pressure for 5 cycles
        send(32'h3FC00000, 1'b0, 1'b0);
        push_exp(32'h40600000, 1'b0);
        send(32'h40000000, 1'b0, 1'b1);
        collect("hold", 4, 5);

        // reset during NORM aborts the vector
        send(32'h40400000, 1'b0, 1'b0);
        send(32'hC0200000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_in_ready",  32'(in_ready),  32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_sum",   out_sum,        32'd0);
        check("abort_out_ovf",   32'(out_ovf),   32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // partial sum discarded: fresh vector sees only its own operand
        push_exp(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        collect("after_abort", 1, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
